sparse_conv_scheduler: RTL and testbench
========================================

SPARSE_CONV_SCHEDULER -- requirements
Module: sparse_conv_scheduler

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 28, input feature map edge length in pixels.
REQ-002 SHALL have parameter KERNEL_SIZE, default 5, kernel edge length.
REQ-003 SHALL have parameter WORD_LENGTH, default 8, feature/weight/coordinate width.
REQ-004 SHALL have parameter MAX_NNZ, default 25, weight table depth (= KERNEL_SIZE*KERNEL_SIZE).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  in  1  begin a convolution job (sampled only in IDLE).
REQ-008 SHALL have ports w_valid in 1, w_ready out 1, w_last in 1, w_value in WORD_LENGTH (signed), w_row in WORD_LENGTH, w_col in WORD_LENGTH  sparse weight entry load channel.
REQ-009 SHALL have ports f_valid in 1, f_ready out 1, f_data in WORD_LENGTH (signed)  raster-order feature pixel stream.
REQ-010 SHALL have ports pe_valid out 1, pe_feature out WORD_LENGTH, pe_weight out WORD_LENGTH, pe_out_row out WORD_LENGTH, pe_out_col out WORD_LENGTH  product issue to PE/accumulator.
REQ-011 SHALL have ports acc_clear out 1, busy out 1, done out 1, nnz out WORD_LENGTH  accumulator clear pulse, job active, job complete pulse, stored weight count.

Function
REQ-012 SHALL implement states IDLE, LOAD, STREAM, FLUSH, DONE; busy=1 in all states except IDLE.
REQ-013 IDLE: w_ready=0, f_ready=0; start=1 -> LOAD next cycle, nnz cleared to 0, acc_clear=1 for exactly that one cycle; start outside IDLE ignored.
REQ-014 LOAD: w_ready=1; each w_valid&w_ready handshake stores {w_value,w_row,w_col} at table index nnz and increments nnz.
REQ-015 Entry dropped (not stored, nnz unchanged) when w_value==0, w_row>=KERNEL_SIZE, w_col>=KERNEL_SIZE, or nnz==MAX_NNZ; w_last still honoured on a dropped entry.
REQ-016 Handshake with w_last=1 -> STREAM next cycle; pixel counters in_row=in_col=0.
REQ-017 STREAM fetch: f_ready=1; on f_valid&f_ready pixel accepted; in_col increments, wraps to 0 at IMAGE_SIZE-1 with in_row increment; f_valid=0 holds all counters.
REQ-018 Accepted pixel with f_data==0, or nnz==0, SHALL consume exactly one cycle and issue nothing.
REQ-019 Accepted nonzero pixel SHALL be latched, then iterate k=0..nnz-1, one k per cycle, f_ready=0 except in the cycle of k=nnz-1 (back-to-back: nnz cycles per nonzero pixel).
REQ-020 Per k: out_row=in_row-w_row[k], out_col=in_col-w_col[k] (signed, WORD_LENGTH+1 bits); product issued only if 0<=out_row<=IMAGE_SIZE-KERNEL_SIZE and same for out_col; out-of-range k still costs its cycle.
REQ-021 pe_* outputs SHALL be registered, valid one cycle after the iteration cycle; pe_feature=latched pixel, pe_weight=w_value[k]; pe_valid=0 leaves other pe_* at 0.
REQ-022 After iteration of the IMAGE_SIZE*IMAGE_SIZE-th pixel completes -> FLUSH (one cycle, last pe_valid may appear) -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; weight table and nnz retained until next start.
REQ-024 f_ready SHALL be 0 outside STREAM; w_ready SHALL be 0 outside LOAD.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, nnz=0, counters=0, and all outputs 0 (w_ready, f_ready, pe_*, acc_clear, busy, done) from the next cycle, regardless of state.
REQ-026 Reset mid-job SHALL abandon the job; a new start is required; partial pe issue SHALL not resume.

Verification
REQ-027 Reset: rst=0 two cycles from arbitrary state -> all outputs 0, busy=0; start then -> acc_clear one-cycle pulse.
REQ-028 Single entry (w=3,row=0,col=0,last), 28x28 image all 1 -> exactly 576 pe_valid, pe_weight=3, coords (r,c) r,c in 0..23 raster order, done one cycle after FLUSH.
REQ-029 25-entry dense kernel (values 0x01,0xff,0xfd,...), all-zero image -> zero pe_valid, done after 784 accepted pixels + FLUSH.
REQ-030 Entries with row=5, col=7, value=0, plus 2 valid entries, last -> nnz=2; 26 valid entries -> nnz=25, 26th dropped.
REQ-031 Single pixel (27,27)=5 nonzero, kernel entry (4,4) -> one issue at (23,23); entry (0,0) for same pixel -> no issue, cycle still consumed.
REQ-032 f_valid random gaps during STREAM -> counters hold, issue order/count identical to gap-free run; rst=0 mid-STREAM -> IDLE, outputs 0 next cycle.

Source files
------------

// File: rtl/sparse_conv_scheduler.sv
// Sparse convolution scheduler: loads a sparse kernel table, streams a raster image and
// issues one (pixel, weight, output coordinate) product per cycle for each nonzero pixel.
module sparse_conv_scheduler #(
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int WORD_LENGTH = 8,
    parameter int MAX_NNZ     = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic                          w_last,
    input  logic signed [WORD_LENGTH-1:0] w_value,
    input  logic        [WORD_LENGTH-1:0] w_row,
    input  logic        [WORD_LENGTH-1:0] w_col,
    input  logic                          f_valid,
    output logic                          f_ready,
    input  logic signed [WORD_LENGTH-1:0] f_data,
    output logic                          pe_valid,
    output logic        [WORD_LENGTH-1:0] pe_feature,
    output logic        [WORD_LENGTH-1:0] pe_weight,
    output logic        [WORD_LENGTH-1:0] pe_out_row,
    output logic        [WORD_LENGTH-1:0] pe_out_col,
    output logic                          acc_clear,
    output logic                          busy,
    output logic                          done,
    output logic        [WORD_LENGTH-1:0] nnz
);
    localparam int W  = WORD_LENGTH;
    localparam int IW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
    localparam logic [W-1:0]        LAST_IDX = W'(IMAGE_SIZE - 1);
    localparam logic [W-1:0]        KS       = W'(KERNEL_SIZE);
    localparam logic [W-1:0]        MAXN     = W'(MAX_NNZ);
    localparam logic signed [W:0]   OMAX     = (W+1)'(IMAGE_SIZE - KERNEL_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, FLUSH, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   nnz_q, nnz_d, in_row_q, in_row_d, in_col_q, in_col_d, k_q, k_d;
    logic [W-1:0]   pix_q, pix_d, prow_q, prow_d, pcol_q, pcol_d;
    logic           iter_q, iter_d, all_in_q, all_in_d, acc_clear_q, acc_clear_d;
    logic           pe_valid_q, pe_valid_d;
    logic [W-1:0]   pe_feature_q, pe_feature_d, pe_weight_q, pe_weight_d;
    logic [W-1:0]   pe_out_row_q, pe_out_row_d, pe_out_col_q, pe_out_col_d;

    logic [W-1:0]   tv [MAX_NNZ];
    logic [W-1:0]   tr [MAX_NNZ];
    logic [W-1:0]   tc [MAX_NNZ];

    logic           w_hs, w_keep, f_acc, last_pix, start_iter, iter_more, in_range;
    logic signed [W:0] orow, ocol;

    always_comb begin
        w_ready    = (state_q == LOAD);
        // While iterating, the next pixel may only be taken on the final k so pixels run back-to-back.
        f_ready    = (state_q == STREAM) && !all_in_q && (!iter_q || k_q == nnz_q - 1'b1);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        acc_clear  = acc_clear_q;
        nnz        = nnz_q;
        pe_valid   = pe_valid_q;
        pe_feature = pe_feature_q;
        pe_weight  = pe_weight_q;
        pe_out_row = pe_out_row_q;
        pe_out_col = pe_out_col_q;

        w_hs       = w_valid && w_ready;
        w_keep     = w_hs && (w_value != '0) && (w_row < KS) && (w_col < KS) && (nnz_q != MAXN);
        f_acc      = f_valid && f_ready;
        last_pix   = (in_row_q == LAST_IDX) && (in_col_q == LAST_IDX);
        start_iter = f_acc && (f_data != '0) && (nnz_q != '0);
        iter_more  = iter_q && (k_q != nnz_q - 1'b1);
        orow       = $signed({1'b0, prow_q}) - $signed({1'b0, tr[k_q[IW-1:0]]});
        ocol       = $signed({1'b0, pcol_q}) - $signed({1'b0, tc[k_q[IW-1:0]]});
        in_range   = !orow[W] && !ocol[W] && (orow <= OMAX) && (ocol <= OMAX);

        state_d      = state_q;
        nnz_d        = nnz_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        k_d          = k_q;
        pix_d        = pix_q;
        prow_d       = prow_q;
        pcol_d       = pcol_q;
        iter_d       = iter_q;
        all_in_d     = all_in_q;
        acc_clear_d  = 1'b0;
        pe_valid_d   = 1'b0;
        pe_feature_d = '0;
        pe_weight_d  = '0;
        pe_out_row_d = '0;
        pe_out_col_d = '0;

        case (state_q)
            IDLE: if (start) begin
                state_d     = LOAD;
                nnz_d       = '0;
                acc_clear_d = 1'b1;
            end
            LOAD: begin
                if (w_keep) nnz_d = nnz_q + 1'b1;
                if (w_hs && w_last) begin
                    state_d  = STREAM;
                    in_row_d = '0;
                    in_col_d = '0;
                    iter_d   = 1'b0;
                    all_in_d = 1'b0;
                end
            end
            STREAM: begin
                if (iter_q) begin
                    k_d = k_q + 1'b1;
                    if (in_range) begin
                        pe_valid_d   = 1'b1;
                        pe_feature_d = pix_q;
                        pe_weight_d  = tv[k_q[IW-1:0]];
                        pe_out_row_d = orow[W-1:0];
                        pe_out_col_d = ocol[W-1:0];
                    end
                end
                iter_d = iter_more;
                if (f_acc) begin
                    if (in_col_q == LAST_IDX) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + 1'b1;
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                    if (last_pix) all_in_d = 1'b1;
                    if (start_iter) begin
                        iter_d = 1'b1;
                        k_d    = '0;
                        pix_d  = f_data;
                        prow_d = in_row_q;
                        pcol_d = in_col_q;
                    end
                end
                if (!(start_iter || iter_more) && (all_in_q || (f_acc && last_pix)))
                    state_d = FLUSH;
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            nnz_q        <= '0;
            in_row_q     <= '0;
            in_col_q     <= '0;
            k_q          <= '0;
            pix_q        <= '0;
            prow_q       <= '0;
            pcol_q       <= '0;
            iter_q       <= 1'b0;
            all_in_q     <= 1'b0;
            acc_clear_q  <= 1'b0;
            pe_valid_q   <= 1'b0;
            pe_feature_q <= '0;
            pe_weight_q  <= '0;
            pe_out_row_q <= '0;
            pe_out_col_q <= '0;
        end else begin
            state_q      <= state_d;
            nnz_q        <= nnz_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            k_q          <= k_d;
            pix_q        <= pix_d;
            prow_q       <= prow_d;
            pcol_q       <= pcol_d;
            iter_q       <= iter_d;
            all_in_q     <= all_in_d;
            acc_clear_q  <= acc_clear_d;
            pe_valid_q   <= pe_valid_d;
            pe_feature_q <= pe_feature_d;
            pe_weight_q  <= pe_weight_d;
            pe_out_row_q <= pe_out_row_d;
            pe_out_col_q <= pe_out_col_d;
        end
    end

    // Table is kept across jobs and reset; only nnz decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_keep) begin
            tv[nnz_q[IW-1:0]] <= w_value;
            tr[nnz_q[IW-1:0]] <= w_row;
            tc[nnz_q[IW-1:0]] <= w_col;
        end
    end
endmodule

// File: tb/tb_sparse_conv_scheduler.sv
// Bench for sparse_conv_scheduler: directed and random jobs checked against a pixel/kernel reference model.
module tb_sparse_conv_scheduler;
    localparam int IS = 28;
    localparam int KS = 5;
    localparam int NP = IS * IS;

    logic       clk = 1'b0;
    logic       rst, start, w_valid, w_last, f_valid;
    logic [7:0] w_value, w_row, w_col, f_data;
    logic       w_ready, f_ready, pe_valid, acc_clear, busy, done;
    logic [7:0] pe_feature, pe_weight, pe_out_row, pe_out_col, nnz;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  ev[$], er[$], ec[$];
    logic [7:0]  img [NP];
    logic [31:0] expq[$];

    sparse_conv_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .w_value(w_value), .w_row(w_row), .w_col(w_col),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .pe_valid(pe_valid), .pe_feature(pe_feature), .pe_weight(pe_weight),
        .pe_out_row(pe_out_row), .pe_out_col(pe_out_col),
        .acc_clear(acc_clear), .busy(busy), .done(done), .nnz(nnz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_e(input int v, input int r, input int c);
        ev.push_back(8'(v)); er.push_back(8'(r)); ec.push_back(8'(c));
    endtask

    task automatic clear_job();
        ev.delete(); er.delete(); ec.delete();
        for (int i = 0; i < NP; i++) img[i] = 8'd0;
    endtask

    // Reference: filter the entry list into the kernel table, then for every nonzero pixel walk
    // the table in order and emit each product whose output coordinate lands in the valid window.
    task automatic model(output int exp_nnz, output int exp_cyc);
        int tv[$], tr[$], tc[$];
        int cyc;
        expq.delete();
        foreach (ev[i])
            if (ev[i] != 0 && er[i] < KS && ec[i] < KS && tv.size() < KS*KS) begin
                tv.push_back(int'(ev[i])); tr.push_back(int'(er[i])); tc.push_back(int'(ec[i]));
            end
        exp_nnz = tv.size();
        cyc = 0;
        for (int r = 0; r < IS; r++)
            for (int c = 0; c < IS; c++) begin
                if (img[r*IS+c] != 0 && exp_nnz > 0) begin
                    cyc += exp_nnz;
                    foreach (tv[k]) begin
                        int orr, occ;
                        orr = r - tr[k];
                        occ = c - tc[k];
                        if (orr >= 0 && orr <= IS-KS && occ >= 0 && occ <= IS-KS)
                            expq.push_back({img[r*IS+c], 8'(tv[k]), 8'(orr), 8'(occ)});
                    end
                end else cyc += 1;
            end
        // Last pixel: FLUSH follows its final iteration (or its accept cycle if nothing iterates).
        exp_cyc = cyc + 1 + ((img[NP-1] != 0 && exp_nnz > 0) ? 1 : 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; start = 0; w_valid = 0; w_last = 0; f_valid = 0;
        repeat (2) @(negedge clk);
        chk({tag, "_outs"}, {w_ready, f_ready, pe_valid, pe_feature, pe_weight, pe_out_row,
                             pe_out_col, acc_clear, busy, done}, 32'd0);
        chk({tag, "_nnz"}, nnz, 0);
        rst = 1'b1;
    endtask

    task automatic run_job(input string name, input int gap_pct, input int abort_cyc);
        int en, ecyc, nexp, p, cyc, got, done_cyc;
        bit idle_ok;
        model(en, ecyc);
        nexp = expq.size();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({name, "_acc_clear"}, acc_clear, 1);
        chk({name, "_busy_load"}, {busy, w_ready, f_ready}, 3'b110);
        foreach (ev[i]) begin
            w_valid = 1'b1; w_value = ev[i]; w_row = er[i]; w_col = ec[i];
            w_last = (i == ev.size() - 1);
            @(negedge clk);
            if (i == 0) chk({name, "_acc_clear_off"}, acc_clear, 0);
        end
        w_valid = 1'b0; w_last = 1'b0;
        chk({name, "_nnz"}, nnz, en);
        chk({name, "_w_ready_off"}, w_ready, 0);
        p = 0; cyc = 0; got = 0; done_cyc = -1; idle_ok = 1'b1;
        while (cyc < 20000) begin
            if (abort_cyc > 0 && cyc == abort_cyc) return;
            if (pe_valid) begin
                if (expq.size() == 0) chk({name, "_pe_extra"}, 1, 0);
                else chk({name, "_pe_issue"}, {pe_feature, pe_weight, pe_out_row, pe_out_col},
                         expq.pop_front());
                got++;
            end else if ({pe_feature, pe_weight, pe_out_row, pe_out_col} !== 32'd0) idle_ok = 1'b0;
            if (done) begin done_cyc = cyc; break; end
            start = ($urandom_range(9) == 0);
            if (p < NP) begin
                f_valid = ($urandom_range(99) >= gap_pct);
                f_data  = img[p];
            end else f_valid = 1'b0;
            if (f_valid && f_ready) p++;
            @(negedge clk);
            cyc++;
        end
        f_valid = 1'b0; start = 1'b0;
        chk({name, "_done_seen"}, done_cyc >= 0, 1);
        chk({name, "_pe_count"}, got, nexp);
        chk({name, "_pe_left"}, expq.size(), 0);
        chk({name, "_pe_idle_zero"}, idle_ok, 1);
        if (gap_pct == 0) chk({name, "_done_cycle"}, done_cyc, ecyc);
        @(negedge clk);
        chk({name, "_after_done"}, {done, busy, f_ready, w_ready}, 0);
        chk({name, "_nnz_kept"}, nnz, en);
    endtask

    task automatic rand_job();
        int n;
        clear_job();
        n = $urandom_range(8, 1);
        for (int i = 0; i < n; i++)
            add_e(($urandom_range(4) == 0) ? 0 : $urandom_range(255),
                  $urandom_range(6), $urandom_range(6));
        for (int i = 0; i < NP; i++)
            img[i] = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
    endtask

    initial begin
        rst = 1'b0; start = 0; w_valid = 0; w_last = 0; f_valid = 0;
        w_value = 0; w_row = 0; w_col = 0; f_data = 0;
        do_reset("reset");

        // Single weight at the kernel origin over an all-ones image.
        clear_job();
        add_e(3, 0, 0);
        for (int i = 0; i < NP; i++) img[i] = 8'd1;
        run_job("ones", 0, 0);

        // Dense 25-entry kernel plus a 26th entry that must be dropped; all-zero image.
        clear_job();
        for (int i = 0; i < KS*KS; i++) add_e(1 - 2*i, i / KS, i % KS);
        add_e(7, 0, 0);
        run_job("dense", 0, 0);

        // Out-of-range and zero entries dropped, two kept; a few nonzero pixels.
        clear_job();
        add_e(3, 5, 0); add_e(2, 0, 7); add_e(0, 1, 1); add_e(4, 1, 2); add_e(255, 4, 4);
        img[0] = 8'd9; img[5*IS+6] = 8'd200; img[NP-1] = 8'd17;
        run_job("drops", 0, 0);

        // Bottom-right pixel with kernel entry (4,4) hits (23,23); with (0,0) it misses.
        clear_job();
        add_e(2, 4, 4);
        img[NP-1] = 8'd5;
        run_job("corner_hit", 0, 0);
        clear_job();
        add_e(2, 0, 0);
        img[NP-1] = 8'd5;
        run_job("corner_miss", 0, 0);

        // Same random job without and with input gaps.
        rand_job();
        run_job("rand_nogap", 0, 0);
        run_job("rand_gap", 35, 0);

        // Abandon a job mid-stream, then prove a fresh job starts cleanly.
        rand_job();
        run_job("abort", 10, 150);
        do_reset("mid_reset");
        rand_job();
        run_job("post_reset", 20, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
